// File: rtl/wishbone_master_sequencer_if.sv
// Command, stream and Wishbone master-port signals of the sequencer.
// The master modport is the sequencer's view; slave is the environment's view.
interface wishbone_master_sequencer_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_wr;
    logic [31:0] i_cmd_adr;
    logic [15:0] i_cmd_count;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic [31:0] i_wr_dat;
    logic        o_rd_valid;
    logic        i_rd_ready;
    logic [31:0] o_rd_dat;
    logic        o_done;
    logic        o_timeout;
    logic        o_int_pending;
    logic        o_m_we;
    logic        o_m_cyc;
    logic        o_m_stb;
    logic [3:0]  o_m_sel;
    logic [31:0] o_m_adr;
    logic [31:0] o_m_dat;
    logic [31:0] i_m_dat;
    logic        i_m_ack;
    logic        i_m_int;

    modport master (
        input  i_cmd_valid, i_cmd_wr, i_cmd_adr, i_cmd_count,
        input  i_wr_valid, i_wr_dat, i_rd_ready,
        input  i_m_dat, i_m_ack, i_m_int,
        output o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_dat,
        output o_done, o_timeout, o_int_pending,
        output o_m_we, o_m_cyc, o_m_stb, o_m_sel, o_m_adr, o_m_dat
    );

    modport slave (
        output i_cmd_valid, i_cmd_wr, i_cmd_adr, i_cmd_count,
        output i_wr_valid, i_wr_dat, i_rd_ready,
        output i_m_dat, i_m_ack, i_m_int,
        input  o_cmd_ready, o_wr_ready, o_rd_valid, o_rd_dat,
        input  o_done, o_timeout, o_int_pending,
        input  o_m_we, o_m_cyc, o_m_stb, o_m_sel, o_m_adr, o_m_dat
    );
endinterface

// File: rtl/wishbone_master_sequencer.sv
// Command-driven Wishbone master: one single-word transfer per command word,
// auto-incrementing address, streamed write/read data and a per-transfer ack timeout.
//
//   state   | meaning
//   S_IDLE  | waiting for a command, cmd_ready high, bus released
//   S_FETCH | write: waiting for the next write word
//   S_REQ   | strobe asserted, waiting for ack or timeout
//   S_RESP  | read: holding the captured word until the consumer takes it
//   S_DONE  | one-cycle completion pulse, bus released
module wishbone_master_sequencer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_INC       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    wishbone_master_sequencer_if.master    bus
);

    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   ADR_STEP = 32'(ADDR_INC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          accept;
    logic          take_wr;
    logic          ack_take;
    logic          tmo_fire;
    logic          cyc;

    logic          we_q;
    logic [15:0]   remaining;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;
    logic [31:0]   rd_dat_q;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_q;
    logic          int_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        take_wr   = 1'b0;
        ack_take  = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_cmd_valid) begin
                    accept = 1'b1;
                    if (bus.i_cmd_count == 16'd0) begin
                        state_nxt = S_DONE;
                    end else if (bus.i_cmd_wr) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_FETCH: begin
                if (bus.i_wr_valid) begin
                    take_wr   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // An ack arriving on the expiry edge still completes the word.
                if (bus.i_m_ack) begin
                    ack_take = 1'b1;
                    if (!we_q) begin
                        state_nxt = S_RESP;
                    end else if (remaining == 16'd1) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end else if (tmo_cnt == '0) begin
                    tmo_fire  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                if (bus.i_rd_ready) begin
                    state_nxt = (remaining == 16'd0) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            remaining <= 16'd0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            rd_dat_q  <= 32'd0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            timeout_q <= tmo_fire;
            int_q     <= bus.i_m_int;
            if (accept) begin
                we_q      <= bus.i_cmd_wr;
                adr_q     <= bus.i_cmd_adr;
                remaining <= bus.i_cmd_count;
            end
            if (take_wr) begin
                dat_q <= bus.i_wr_dat;
            end
            if (ack_take) begin
                remaining <= remaining - 16'd1;
                adr_q     <= adr_q + ADR_STEP;
                if (!we_q) begin
                    rd_dat_q <= bus.i_m_dat;
                end
            end
            // Reload on every entry into REQ so each word gets a full budget.
            if (state_nxt == S_REQ && state != S_REQ) begin
                tmo_cnt <= TMO_LOAD;
            end else if (state == S_REQ && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end
        end
    end

    assign cyc               = (state == S_FETCH) || (state == S_REQ) || (state == S_RESP);

    assign bus.o_cmd_ready   = (state == S_IDLE);
    assign bus.o_wr_ready    = (state == S_FETCH);
    assign bus.o_rd_valid    = (state == S_RESP);
    assign bus.o_done        = (state == S_DONE);
    assign bus.o_timeout     = timeout_q;
    assign bus.o_int_pending = int_q;
    assign bus.o_m_cyc       = cyc;
    assign bus.o_m_stb       = (state == S_REQ);
    assign bus.o_m_we        = cyc & we_q;
    assign bus.o_m_sel       = cyc ? 4'hF : 4'h0;
    assign bus.o_m_adr       = adr_q;
    assign bus.o_m_dat       = dat_q;
    assign bus.o_rd_dat      = rd_dat_q;

endmodule

// File: tb/tb_wishbone_master_sequencer.sv
// Bench for wishbone_master_sequencer: table of commands plus randomized commands
// against a word-level model, with a scripted slave and hand-written corner sequences.
module tb_wishbone_master_sequencer;

    localparam int          TMO = 8;
    localparam logic [31:0] INC = 32'd1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wishbone_master_sequencer_if bus();

    wishbone_master_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_INC       (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    typedef struct {
        logic        wr;
        logic [31:0] adr;
        logic [15:0] cnt;
        int          wait_st;
        int          rd_pct;
        int          rd_hold;
        int          gap2;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        exp_done;
        logic        exp_tmo;
        logic [31:0] exp_adr;
        int          exp_lat;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    string ctx = "init";

    // environment knobs
    int slave_wait = 0;
    bit glitch_en  = 1'b0;
    int rd_pct     = 100;
    int rd_block   = 0;
    int gap_left   = 0;
    int wcnt       = 0;
    logic [31:0] wr_src[$];
    int          wr_gap[$];

    // monitor results
    xfer_t       bus_log[$];
    logic [31:0] rd_log[$];
    xfer_t       mon_x;
    int  done_cnt = 0, tmo_cnt = 0, stb_cycles = 0, stall_cycles = 0;
    bit  cyc_seen = 1'b0, wr_fired = 1'b0, prev_stall = 1'b0;
    logic [31:0] prev_rd_dat = 32'd0;

    vec_t tv[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", ctx, name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit dead(input logic [31:0] a);
        return a[31:24] == 8'h05;
    endfunction

    // slave: acks after slave_wait extra cycles, never for the 0x05 slave
    initial begin
        bus.i_m_ack = 1'b0;
        bus.i_m_dat = 32'd0;
        forever begin
            @(posedge clk); #1;
            bus.i_m_dat = $urandom;
            if (bus.o_m_stb && !dead(bus.o_m_adr)) begin
                if (wcnt >= slave_wait) begin
                    bus.i_m_ack = 1'b1;
                    wcnt = 0;
                    if (!bus.o_m_we) bus.i_m_dat = rd_fn(bus.o_m_adr);
                end else begin
                    bus.i_m_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.i_m_ack = glitch_en && !bus.o_m_stb && ($urandom_range(0, 3) == 0);
                wcnt = 0;
            end
        end
    end

    // write-data source with per-word gaps
    initial begin
        bus.i_wr_valid = 1'b0;
        bus.i_wr_dat   = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (wr_fired) begin
                wr_fired = 1'b0;
                if (wr_src.size() > 0) begin
                    void'(wr_src.pop_front());
                    void'(wr_gap.pop_front());
                end
                gap_left = (wr_gap.size() > 0) ? wr_gap[0] : 0;
            end
            if (wr_src.size() > 0 && gap_left == 0) begin
                bus.i_wr_valid = 1'b1;
                bus.i_wr_dat   = wr_src[0];
            end else begin
                bus.i_wr_valid = 1'b0;
                bus.i_wr_dat   = $urandom;
                if (gap_left > 0) gap_left--;
            end
        end
    end

    // read consumer
    initial begin
        bus.i_rd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.o_rd_valid && rd_block > 0) begin
                bus.i_rd_ready = 1'b0;
                rd_block--;
            end else begin
                bus.i_rd_ready = ($urandom_range(1, 100) <= rd_pct);
            end
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_m_stb) stb_cycles++;
                if (bus.o_m_cyc) cyc_seen = 1'b1;
                if (bus.o_done) done_cnt++;
                if (bus.o_timeout) tmo_cnt++;
                if (bus.o_m_stb && bus.i_m_ack) begin
                    mon_x.we  = bus.o_m_we;
                    mon_x.adr = bus.o_m_adr;
                    mon_x.dat = bus.o_m_we ? bus.o_m_dat : bus.i_m_dat;
                    bus_log.push_back(mon_x);
                end
                if (bus.i_wr_valid && bus.o_wr_ready) wr_fired = 1'b1;
                if (bus.o_rd_valid && bus.i_rd_ready) rd_log.push_back(bus.o_rd_dat);
                if (prev_stall) begin
                    check("rd_hold_valid", 64'(bus.o_rd_valid), 64'd1);
                    check("rd_hold_dat", 64'(bus.o_rd_dat), 64'(prev_rd_dat));
                    check("rd_hold_stb", 64'(bus.o_m_stb), 64'd0);
                end
                prev_stall  = bus.o_rd_valid && !bus.i_rd_ready;
                prev_rd_dat = bus.o_rd_dat;
                if (prev_stall) stall_cycles++;
                check("sel", 64'(bus.o_m_sel), bus.o_m_cyc ? 64'hF : 64'h0);
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic wr, input logic [31:0] adr, input logic [15:0] cnt, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_wr    = wr;
        bus.i_cmd_adr   = adr;
        bus.i_cmd_count = cnt;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (bus.o_cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_count = $urandom;
        check("cmd_accept", 64'(ok), 64'd1);
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] adr, input logic [15:0] cnt,
                           input bit use_tbl, input logic tb_done, input logic tb_tmo,
                           input logic [31:0] tb_adr, input int tb_lat);
        xfer_t       exp_x[$];
        logic [31:0] exp_rd[$];
        logic [31:0] wdata[$];
        xfer_t       x;
        logic [31:0] a;
        int          exp_stb;
        int          hold0;
        int          lat;
        bit          m_tmo;
        bit          ok;
        bit          fin;

        wdata = wr_src;
        hold0 = rd_block;
        exp_stb = 0;
        m_tmo = 1'b0;
        a = adr;
        for (int i = 0; i < int'(cnt); i++) begin
            if (dead(a) || slave_wait >= TMO) begin
                exp_stb += TMO;
                m_tmo = 1'b1;
                break;
            end
            exp_stb += slave_wait + 1;
            x.we  = wr;
            x.adr = a;
            x.dat = wr ? ((i < wdata.size()) ? wdata[i] : 32'd0) : rd_fn(a);
            exp_x.push_back(x);
            if (!wr) exp_rd.push_back(x.dat);
            a = a + INC;
        end

        bus_log.delete();
        rd_log.delete();
        done_cnt = 0; tmo_cnt = 0; stb_cycles = 0; stall_cycles = 0; cyc_seen = 1'b0;
        gap_left = (wr_gap.size() > 0) ? wr_gap[0] : 0;

        issue(wr, adr, cnt, ok);
        fin = 1'b0;
        lat = 0;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            lat++;
            if (bus.o_done || bus.o_timeout) fin = 1'b1;
        end
        check("completion", 64'(fin), 64'd1);
        check("end_cyc", 64'(bus.o_m_cyc), 64'd0);
        check("end_stb", 64'(bus.o_m_stb), 64'd0);
        if (bus.o_timeout) check("tmo_ready", 64'(bus.o_cmd_ready), 64'd1);
        repeat (3) @(negedge clk);

        check("done_cnt", 64'(done_cnt), m_tmo ? 64'd0 : 64'd1);
        check("tmo_cnt", 64'(tmo_cnt), m_tmo ? 64'd1 : 64'd0);
        check("xfer_count", 64'(bus_log.size()), 64'(exp_x.size()));
        for (int i = 0; i < exp_x.size() && i < bus_log.size(); i++) begin
            check("xfer_we", 64'(bus_log[i].we), 64'(exp_x[i].we));
            check("xfer_adr", 64'(bus_log[i].adr), 64'(exp_x[i].adr));
            check("xfer_dat", 64'(bus_log[i].dat), 64'(exp_x[i].dat));
        end
        check("rd_count", 64'(rd_log.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
            check("rd_dat", 64'(rd_log[i]), 64'(exp_rd[i]));
        end
        check("stb_cycles", 64'(stb_cycles), 64'(exp_stb));
        check("cyc_seen", 64'(cyc_seen), (cnt != 16'd0) ? 64'd1 : 64'd0);
        check("final_adr", 64'(bus.o_m_adr), 64'(a));
        if (rd_pct == 100 && exp_rd.size() > 0) check("rd_stall", 64'(stall_cycles), 64'(hold0));
        if (use_tbl) begin
            check("tbl_done", 64'(done_cnt), 64'(tb_done));
            check("tbl_tmo", 64'(tmo_cnt), 64'(tb_tmo));
            check("tbl_adr", 64'(bus.o_m_adr), 64'(tb_adr));
            if (tb_lat >= 0) check("tbl_latency", 64'(lat), 64'(tb_lat));
        end

        wr_src.delete();
        wr_gap.delete();
        wr_fired = 1'b0;
        gap_left = 0;
        rd_block = 0;
    endtask

    initial begin
        logic [7:0]  int_pat;
        logic        int_prev;
        logic [31:0] radr;
        bit          ok;
        bit          fin;

        //           wr    adr           cnt    wt  pct hold gap  d0            d1            done  tmo   exp_adr       lat
        tv[0]  = '{1'b0, 32'h0100_0010, 16'd3, 1, 100, 0, 0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0100_0013, -1};
        tv[1]  = '{1'b1, 32'h0000_0000, 16'd2, 0, 100, 0, 3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0002, -1};
        tv[2]  = '{1'b0, 32'h0500_0000, 16'd1, 0, 100, 0, 0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0500_0000,  9};
        tv[3]  = '{1'b0, 32'h0200_0000, 16'd0, 0, 100, 0, 0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0200_0000,  1};
        tv[4]  = '{1'b1, 32'hFFFF_FFFE, 16'd3, 2, 100, 0, 1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b1, 1'b0, 32'h0000_0001, -1};
        tv[5]  = '{1'b0, 32'h04FF_FFFF, 16'd3, 0,  70, 0, 0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0500_0000, -1};
        tv[6]  = '{1'b1, 32'h0500_0010, 16'd2, 0, 100, 0, 0, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b1, 32'h0500_0010, 10};
        tv[7]  = '{1'b0, 32'h0300_0100, 16'd4, 7, 100, 0, 0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0300_0104, -1};
        tv[8]  = '{1'b0, 32'h0300_0100, 16'd2, 8, 100, 0, 0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0300_0100,  9};
        tv[9]  = '{1'b0, 32'h0100_0020, 16'd2, 0, 100, 5, 0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0100_0022, 10};
        tv[10] = '{1'b0, 32'h0000_0040, 16'd1, 0, 100, 0, 0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_0041,  3};
        tv[11] = '{1'b1, 32'h0000_0080, 16'd1, 0, 100, 0, 0, 32'h0BAD_F00D, 32'h0,         1'b1, 1'b0, 32'h0000_0081,  3};
        tv[12] = '{1'b1, 32'h0700_0000, 16'd2, 7, 100, 0, 0, 32'hCAFE_0001, 32'hCAFE_0002, 1'b1, 1'b0, 32'h0700_0002, -1};

        rst = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_wr    = 1'b0;
        bus.i_cmd_adr   = 32'd0;
        bus.i_cmd_count = 16'd0;
        bus.i_m_int     = 1'b0;

        ctx = "reset";
        repeat (3) @(negedge clk);
        check("cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("wr_ready", 64'(bus.o_wr_ready), 64'd0);
        check("rd_valid", 64'(bus.o_rd_valid), 64'd0);
        check("rd_dat", 64'(bus.o_rd_dat), 64'd0);
        check("done", 64'(bus.o_done), 64'd0);
        check("timeout", 64'(bus.o_timeout), 64'd0);
        check("int_pending", 64'(bus.o_int_pending), 64'd0);
        check("m_we", 64'(bus.o_m_we), 64'd0);
        check("m_cyc", 64'(bus.o_m_cyc), 64'd0);
        check("m_stb", 64'(bus.o_m_stb), 64'd0);
        check("m_adr", 64'(bus.o_m_adr), 64'd0);
        check("m_dat", 64'(bus.o_m_dat), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        ctx = "int";
        int_pat  = 8'b1011_0010;
        int_prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.i_m_int = int_pat[k];
            @(negedge clk);
            check("int_pending", 64'(bus.o_int_pending), 64'(int_prev));
            int_prev = int_pat[k];
        end
        @(posedge clk); #1;
        bus.i_m_int = 1'b0;

        for (int v = 0; v < 13; v++) begin
            ctx = $sformatf("tbl%0d", v);
            slave_wait = tv[v].wait_st;
            rd_pct     = tv[v].rd_pct;
            rd_block   = tv[v].rd_hold;
            if (tv[v].wr) begin
                for (int i = 0; i < int'(tv[v].cnt); i++) begin
                    wr_src.push_back(i == 0 ? tv[v].d0 : (i == 1 ? tv[v].d1 : $urandom));
                    wr_gap.push_back(i == 1 ? tv[v].gap2 : 0);
                end
            end
            run_cmd(tv[v].wr, tv[v].adr, tv[v].cnt, 1'b1, tv[v].exp_done, tv[v].exp_tmo,
                    tv[v].exp_adr, tv[v].exp_lat);
        end

        glitch_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic        rwr;
            logic [15:0] rcnt;
            int          sel;
            ctx  = $sformatf("rnd%0d", r);
            rwr  = 1'($urandom_range(0, 1));
            rcnt = 16'($urandom_range(0, 5));
            sel  = $urandom_range(0, 9);
            radr = $urandom;
            if (sel == 0) radr[31:24] = 8'h05;
            else if (sel == 1) radr = 32'h04FF_FFFE;
            else if (sel == 2) radr = 32'hFFFF_FFFD;
            slave_wait = ($urandom_range(0, 5) == 0) ? $urandom_range(7, 9) : $urandom_range(0, 3);
            rd_pct     = $urandom_range(40, 100);
            rd_block   = $urandom_range(0, 3);
            if (rwr) begin
                for (int i = 0; i < int'(rcnt); i++) begin
                    wr_src.push_back($urandom);
                    wr_gap.push_back(i == 0 ? 0 : $urandom_range(0, 3));
                end
            end
            run_cmd(rwr, radr, rcnt, 1'b0, 1'b0, 1'b0, 32'd0, -1);
        end
        glitch_en = 1'b0;

        ctx = "async_rst";
        slave_wait = 5;
        rd_pct = 100;
        for (int i = 0; i < 4; i++) begin
            wr_src.push_back(32'h6000_0000 + 32'(i));
            wr_gap.push_back(0);
        end
        gap_left = 0;
        issue(1'b1, 32'h0600_0000, 16'd4, ok);
        done_cnt = 0;
        tmo_cnt  = 0;
        fin = 1'b0;
        for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk);
            if (bus.o_m_stb) fin = 1'b1;
        end
        check("reach_req", 64'(fin), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("cyc_async", 64'(bus.o_m_cyc), 64'd0);
        check("stb_async", 64'(bus.o_m_stb), 64'd0);
        check("we_async", 64'(bus.o_m_we), 64'd0);
        check("sel_async", 64'(bus.o_m_sel), 64'd0);
        wr_src.delete();
        wr_gap.delete();
        wr_fired = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("idle_cyc", 64'(bus.o_m_cyc), 64'd0);
        repeat (4) @(negedge clk);
        check("no_done", 64'(done_cnt), 64'd0);
        check("no_tmo", 64'(tmo_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wishbone_master_sequencer.md
# wishbone_master_sequencer

Command-driven Wishbone master that sits directly upstream of the wishbone interconnect and drives its master-side port. It accepts a read or write command (start address, word count), issues one single-word Wishbone transfer per word with auto-incrementing address, and streams write data in and read data out over valid/ready handshakes. A per-transfer ack timeout prevents a missing or unselected slave from hanging the bus. The interconnect returns ack=0 for unmapped addresses, so the timeout is the only way out of that case.

## Interface
- TIMEOUT_CYCLES, 256: cycles of stb without ack before a transfer aborts; minimum 2.
- ADDR_INC, 1: added to o_m_adr after each acked word.

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_wr  in  1  1=write, 0=read
- i_cmd_adr  in  32  start address ([31:24] selects the slave)
- i_cmd_count  in  16  number of words; 0 = no bus activity
- i_wr_valid  in  1  write word present
- o_wr_ready  out  1  write word taken when valid&ready
- i_wr_dat  in  32  write word
- o_rd_valid  out  1  read word present
- i_rd_ready  in  1  read word consumed when valid&ready
- o_rd_dat  out  32  read word
- o_done  out  1  one-cycle pulse, command completed
- o_timeout  out  1  one-cycle pulse, command aborted
- o_int_pending  out  1  i_m_int registered by one cycle
- o_m_we, o_m_cyc, o_m_stb  out  1  Wishbone controls
- o_m_sel  out  4  constant 4'hF while o_m_cyc=1, else 0
- o_m_adr  out  32  Wishbone address
- o_m_dat  out  32  Wishbone write data
- i_m_dat  in  32  Wishbone read data
- i_m_ack  in  1  Wishbone ack
- i_m_int  in  1  aggregated slave interrupt

## Operation
- States: IDLE, FETCH, REQ, RESP, DONE.
- IDLE:
  - o_cmd_ready=1 in IDLE only.
  - On accept, latch we, adr, remaining=count.
  - count=0 goes to DONE.
  - Otherwise, write goes to FETCH and read goes to REQ.
  - o_m_cyc rises on leaving IDLE for FETCH or REQ. It stays high until DONE or timeout.
- FETCH:
  - o_wr_ready=1.
  - On i_wr_valid, latch i_wr_dat into o_m_dat and go to REQ.
- REQ:
  - o_m_stb=1; o_m_we=latched we.
  - The timeout counter clears on entry.
  - On i_m_ack:
    - remaining decrements.
    - o_m_adr advances by ADDR_INC, modulo 2^32. A carry into [31:24] is not special-cased.
    - stb drops.
    - A read captures i_m_dat into o_rd_dat and goes to RESP.
    - A write goes to DONE if remaining is now 0, otherwise to FETCH.
- RESP:
  - o_rd_valid=1.
  - On i_rd_ready, go to DONE if remaining is 0, otherwise to REQ.
- DONE:
  - o_done=1 for one cycle.
  - cyc and stb are 0.
  - Next state is IDLE.
- Timeout:
  - Applies when REQ has held stb for TIMEOUT_CYCLES cycles with no ack.
  - Next cycle: cyc, stb and we are 0, o_timeout=1 for one cycle, state is IDLE.
  - o_done is not pulsed.
  - Remaining words are discarded. The caller must drain nothing.
- i_m_ack outside REQ is ignored.
- An ack on the same edge the timeout expires wins: the transfer completes normally.
- o_m_adr and o_m_dat hold their values outside REQ; only stb/cyc qualify them.
- o_int_pending tracks i_m_int in every state.

## Timing
- Reset values:
  - o_cmd_ready=1 (state IDLE).
  - All other outputs 0, including o_m_adr, o_m_dat and o_rd_dat.
- Reset mid-command: the bus is released immediately (async), and no done or timeout pulse is issued.
- Read, one word:
  - Command accepted at edge 0.
  - cyc/stb high from cycle 1.
  - Ack sampled at edge n.
  - o_rd_valid high in cycle n+1 with stb low.
- Write, one word:
  - Accept at edge 0; wr_ready in cycle 1.
  - If i_wr_valid is already high, stb rises in cycle 2.
- Per-word minimum cost, with zero-wait slave and no backpressure:
  - Read: 2 cycles (REQ, RESP).
  - Write: 2 cycles (FETCH, REQ).
- DONE occupies one cycle; the next command is accepted no earlier than the cycle after DONE.
- Address wrap: 0xFFFFFFFF + 1 = 0x00000000.

## Test plan
- Read, count=3, adr=0x01000010, slave acks after 1 wait state, i_rd_ready=1 -> o_m_adr 0x01000010/11/12 and three o_rd_valid pulses carrying the slave data in order, then o_done=1 once and cyc=0.
- Write, count=2, adr=0x00000000, data 0xDEADBEEF then 0x12345678, i_wr_valid delayed 3 cycles before word 2 -> stb low during the wait, and each stb carries the correct o_m_dat/o_m_adr. Expect o_done.
- Read at adr=0x05000000, ack never asserts, TIMEOUT_CYCLES=8 -> stb high exactly 8 cycles, then o_timeout pulse, no o_done, cyc=0 and o_cmd_ready=1.
- count=0 command -> o_m_cyc never rises, o_done one cycle after accept.
- Read, count=2 with i_rd_ready held low 5 cycles -> o_rd_valid and o_rd_dat stable, and no second stb until the handshake.
- Async rst asserted mid-REQ of a 4-word write -> cyc/stb drop without waiting for a clock edge. After release the block is in IDLE and o_done/o_timeout never pulsed.
